// File: rtl/led_framebuffer_if.sv
// Pixel-writer, commit/frame and read-back signals of the double-buffered LED framebuffer.
// The master is the writer/driver side and the slave is the framebuffer.
interface led_framebuffer_if;
  logic       wr_valid;
  logic       wr_ready;
  logic [7:0] wr_index;
  logic [7:0] wr_red;
  logic [7:0] wr_green;
  logic [7:0] wr_blue;
  logic       commit;
  logic       commit_pending;
  logic       frame_start;
  logic [7:0] address;
  logic [7:0] red;
  logic [7:0] green;
  logic [7:0] blue;
  logic       active_bank;

  modport master (
    output wr_valid, wr_index, wr_red, wr_green, wr_blue,
    output commit, frame_start, address,
    input  wr_ready, commit_pending, red, green, blue, active_bank
  );

  modport slave (
    input  wr_valid, wr_index, wr_red, wr_green, wr_blue,
    input  commit, frame_start, address,
    output wr_ready, commit_pending, red, green, blue, active_bank
  );
endinterface

// File: rtl/led_framebuffer.sv
// Double-buffered 24-bit pixel store for a WS2811 driver: the writer fills the back bank,
// and a commit swaps banks on the next frame boundary (or at once if it coincides with one).
module led_framebuffer #(
  parameter int NUM_LEDS = 150
) (
  input logic          clk,
  input logic          reset,
  led_framebuffer_if.slave fb
);

  localparam int         AW   = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
  localparam logic [7:0] LAST = 8'(NUM_LEDS - 1);

  typedef enum logic [1:0] {
    CLEAR,
    RUN,
    PENDING
  } state_t;

  state_t      state;
  logic [7:0]  clr_cnt;
  logic        bank;
  logic        pending;
  logic        ready;
  logic        wr_fire;
  logic [23:0] mem [2][NUM_LEDS];
  logic [23:0] rgb_p1;

  function automatic logic in_range(input logic [7:0] idx);
    return {1'b0, idx} < 9'(NUM_LEDS);
  endfunction

  // Out-of-range writes still complete the handshake but never reach memory.
  assign wr_fire = fb.wr_valid & fb.wr_ready & in_range(fb.wr_index);

  // Control FSM; ready, pending and bank are registered alongside the state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= CLEAR;
      clr_cnt <= '0;
      bank    <= 1'b0;
      pending <= 1'b0;
      ready   <= 1'b0;
    end else begin
      case (state)
        CLEAR: begin
          if (clr_cnt == LAST) begin
            state <= RUN;
            ready <= 1'b1;
          end else begin
            clr_cnt <= clr_cnt + 8'd1;
          end
        end
        RUN: begin
          if (fb.commit && fb.frame_start) begin
            bank <= ~bank;
          end else if (fb.commit) begin
            state   <= PENDING;
            pending <= 1'b1;
            ready   <= 1'b0;
          end
        end
        PENDING: begin
          if (fb.frame_start) begin
            bank    <= ~bank;
            pending <= 1'b0;
            ready   <= 1'b1;
            state   <= RUN;
          end
        end
        default: begin
          state   <= CLEAR;
          clr_cnt <= '0;
          ready   <= 1'b0;
          pending <= 1'b0;
        end
      endcase
    end
  end

  // Pixel memory: CLEAR zeroes both banks, RUN writes land in the back bank.
  always_ff @(posedge clk) begin
    if (state == CLEAR) begin
      mem[0][clr_cnt[AW-1:0]] <= '0;
      mem[1][clr_cnt[AW-1:0]] <= '0;
    end else if (wr_fire) begin
      mem[~bank][fb.wr_index[AW-1:0]] <= {fb.wr_red, fb.wr_green, fb.wr_blue};
    end
  end

  // Read stage p1: bank, state and address are all taken from the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      rgb_p1 <= '0;
    end else if ((state == CLEAR) || !in_range(fb.address)) begin
      rgb_p1 <= '0;
    end else begin
      rgb_p1 <= mem[bank][fb.address[AW-1:0]];
    end
  end

  assign fb.wr_ready       = ready & ~reset;
  assign fb.commit_pending = pending;
  assign fb.active_bank    = bank;
  assign fb.red            = rgb_p1[23:16];
  assign fb.green          = rgb_p1[15:8];
  assign fb.blue           = rgb_p1[7:0];

endmodule

// File: tb/tb_led_framebuffer.sv
// Directed bench for led_framebuffer: status checks inline, read data checked by a
// queue-fed monitor one cycle after each address is presented.
module tb_led_framebuffer;

  logic clk;
  logic reset;
  logic rd_chk;
  int   n_cmp;
  int   n_bad;
  logic [23:0] exp_q[$];

  led_framebuffer_if fb();

  led_framebuffer #(.NUM_LEDS(150)) dut (
    .clk   (clk),
    .reset (reset),
    .fb    (fb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [7:0] addr, input logic [23:0] exp);
    fb.address = addr;
    rd_chk     = 1'b1;
    exp_q.push_back(exp);
    tick();
    rd_chk     = 1'b0;
  endtask

  task automatic wr(input logic [7:0] idx, input logic [7:0] r, input logic [7:0] g,
                    input logic [7:0] b);
    chk("wr_ready_at_write", 32'(fb.wr_ready), 32'd1);
    fb.wr_valid = 1'b1;
    fb.wr_index = idx;
    fb.wr_red   = r;
    fb.wr_green = g;
    fb.wr_blue  = b;
    tick();
    fb.wr_valid = 1'b0;
  endtask

  task automatic wait_ready(input int exp_cycles);
    int n;
    n = 0;
    while (fb.wr_ready !== 1'b1 && n < 400) begin
      tick();
      n++;
    end
    chk("clear_length", 32'(n), 32'(exp_cycles));
  endtask

  task automatic swap_now();
    fb.commit      = 1'b1;
    fb.frame_start = 1'b1;
    tick();
    fb.commit      = 1'b0;
    fb.frame_start = 1'b0;
  endtask

  // Read-data monitor
  initial begin
    logic [23:0] e;
    forever begin
      @(posedge clk);
      if (rd_chk) begin
        @(negedge clk);
        if (exp_q.size() == 0) begin
          chk("rd_queue_underflow", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("rd_rgb", 32'({fb.red, fb.green, fb.blue}), 32'(e));
        end
      end
    end
  end

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rd_chk = 1'b0;
    reset = 1'b1;
    fb.wr_valid = 1'b0;
    fb.wr_index = '0;
    fb.wr_red = '0;
    fb.wr_green = '0;
    fb.wr_blue = '0;
    fb.commit = 1'b0;
    fb.frame_start = 1'b0;
    fb.address = '0;

    // Reset and clear sequence
    tick();
    tick();
    chk("rst_wr_ready", 32'(fb.wr_ready), 32'd0);
    chk("rst_pending", 32'(fb.commit_pending), 32'd0);
    chk("rst_active_bank", 32'(fb.active_bank), 32'd0);
    chk("rst_rgb", 32'({fb.red, fb.green, fb.blue}), 32'd0);
    reset = 1'b0;
    wait_ready(150);
    fb.frame_start = 1'b1;
    tick();
    fb.frame_start = 1'b0;
    chk("lone_frame_start_ignored", 32'(fb.active_bank), 32'd0);
    rd(8'd5, 24'h0);
    rd(8'd149, 24'h0);

    // Write, commit, wait for frame boundary
    wr(8'd5, 8'd255, 8'd0, 8'd0);
    fb.commit = 1'b1;
    tick();
    fb.commit = 1'b0;
    chk("pending_set", 32'(fb.commit_pending), 32'd1);
    chk("pending_wr_ready", 32'(fb.wr_ready), 32'd0);
    chk("pending_bank", 32'(fb.active_bank), 32'd0);
    rd(8'd5, 24'h0);
    fb.frame_start = 1'b1;
    tick();
    fb.frame_start = 1'b0;
    chk("swap_bank", 32'(fb.active_bank), 32'd1);
    chk("swap_pending_clr", 32'(fb.commit_pending), 32'd0);
    chk("swap_wr_ready", 32'(fb.wr_ready), 32'd1);
    rd(8'd5, 24'hFF0000);

    // Commit + frame_start together with a write in the same cycle
    fb.wr_valid = 1'b1;
    fb.wr_index = 8'd0;
    fb.wr_red = 8'd0;
    fb.wr_green = 8'd0;
    fb.wr_blue = 8'd255;
    swap_now();
    fb.wr_valid = 1'b0;
    chk("imm_swap_bank", 32'(fb.active_bank), 32'd0);
    chk("imm_swap_pending", 32'(fb.commit_pending), 32'd0);
    chk("imm_swap_wr_ready", 32'(fb.wr_ready), 32'd1);
    rd(8'd0, 24'h0000FF);
    rd(8'd5, 24'h0);

    // Out-of-range write is accepted and dropped
    wr(8'd200, 8'd1, 8'd2, 8'd3);
    swap_now();
    chk("oor_swap_bank", 32'(fb.active_bank), 32'd1);
    for (int i = 0; i < 150; i++) begin
      rd(8'(i), (i == 5) ? 24'hFF0000 : 24'h0);
    end
    rd(8'd200, 24'h0);
    swap_now();
    rd(8'd0, 24'h0000FF);
    rd(8'd200, 24'h0);

    // Back-to-back reads across a swap
    wr(8'd0, 8'd10, 8'd20, 8'd30);
    wr(8'd1, 8'd11, 8'd21, 8'd31);
    wr(8'd2, 8'd12, 8'd22, 8'd32);
    rd_chk = 1'b1;
    fb.address = 8'd0;
    exp_q.push_back(24'h0000FF);
    fb.commit = 1'b1;
    fb.frame_start = 1'b1;
    tick();
    fb.commit = 1'b0;
    fb.frame_start = 1'b0;
    fb.address = 8'd1;
    exp_q.push_back(24'h0B151F);
    tick();
    fb.address = 8'd2;
    exp_q.push_back(24'h0C1620);
    tick();
    rd_chk = 1'b0;
    chk("b2b_bank", 32'(fb.active_bank), 32'd1);

    // Reset while PENDING
    fb.commit = 1'b1;
    tick();
    fb.commit = 1'b0;
    chk("pre_rst_pending", 32'(fb.commit_pending), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rst2_pending", 32'(fb.commit_pending), 32'd0);
    chk("rst2_bank", 32'(fb.active_bank), 32'd0);
    chk("rst2_wr_ready", 32'(fb.wr_ready), 32'd0);
    fb.commit = 1'b1;
    tick();
    fb.commit = 1'b0;
    wait_ready(149);
    chk("clear_commit_ignored", 32'(fb.commit_pending), 32'd0);
    rd(8'd0, 24'h0);
    rd(8'd1, 24'h0);
    rd(8'd5, 24'h0);

    tick();
    tick();
    chk("rd_queue_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
